// File: rtl/sensedrive_chan_tx_pkg.sv
// sensedrive_chan_tx_pkg: state encodings and synchronizer depth shared by the channel transmitter
package sensedrive_chan_tx_pkg;
    localparam int SYNC_STAGES = 2;
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SETUP = 2'd1,
        TX_REQH  = 2'd2,
        TX_REQL  = 2'd3
    } tx_state_e;
endpackage

// File: rtl/async_bit_sync.sv
// async_bit_sync: N-flop single-bit synchronizer, async active-low reset to 0
module async_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[STAGES-2:0], d_i};
    end
    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/sensedrive_chan_tx.sv
// sensedrive_chan_tx: clocked valid/ready to 4-phase bundled-data push channel, 2-word buffer and watchdog
module sensedrive_chan_tx
    import sensedrive_chan_tx_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_sampler,
    input  logic              rst_sampler_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              chan__out_0r,
    output logic [DATA_W-1:0] chan__out_0d,
    input  logic              chan__out_0a,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    tx_state_e         state_q;
    logic              req_q;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       wd_q, wd_d;
    logic              err_q, err_d;
    logic              ack_s, push, pop, wd_run, wd_hit;

    async_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i (clk_sampler),
        .rst_ni(rst_sampler_n),
        .d_i   (chan__out_0a),
        .q_o   (ack_s)
    );

    assign in_ready = count_q != 2'd2;
    assign push     = in_valid & in_ready;
    assign pop      = (count_q != 2'd0) & ((state_q == TX_IDLE) | ((state_q == TX_REQL) & !ack_s));

    // the watchdog only counts while a phase is still waiting; any phase entry leaves it at zero
    assign wd_run = ((state_q == TX_REQH) & !ack_s) | ((state_q == TX_REQL) & ack_s);
    assign wd_d   = !wd_run ? 16'd0 : (wd_q == WD_LIMIT) ? wd_q : wd_q + 16'd1;
    assign wd_hit = wd_run & (WD_LIMIT != 16'd0) & (wd_q + 16'd1 == WD_LIMIT);
    assign err_d  = wd_hit | (err_q & !err_clr);

    always_ff @(posedge clk_sampler or negedge rst_sampler_n) begin
        if (!rst_sampler_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk_sampler or negedge rst_sampler_n) begin
        if (!rst_sampler_n) begin
            state_q <= TX_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            if (pop) data_q <= mem_q[rd_ptr_q];
            case (state_q)
                TX_IDLE:  if (pop) state_q <= TX_SETUP;
                TX_SETUP: begin
                    req_q   <= 1'b1;
                    state_q <= TX_REQH;
                end
                TX_REQH:  if (ack_s) begin
                    req_q   <= 1'b0;
                    state_q <= TX_REQL;
                end
                TX_REQL:  if (!ack_s) state_q <= pop ? TX_SETUP : TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sampler or negedge rst_sampler_n) begin
        if (!rst_sampler_n) begin
            wd_q  <= 16'd0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign chan__out_0r = req_q;
    assign chan__out_0d = data_q;
    assign busy         = (state_q != TX_IDLE) | (count_q != 2'd0);
    assign timeout_err  = err_q;
endmodule

// File: tb/tb_sensedrive_chan_tx.sv
// tb_sensedrive_chan_tx: table vectors, hand sequences and a word scoreboard for the channel transmitter
module tb_sensedrive_chan_tx;
    typedef struct {
        logic [3:0] data;
        int         dly;
        int         width;
    } vec_t;

    logic       clk = 0, rst_n = 0, in_valid = 0, err_clr = 0, ack_man = 0, ack_resp = 0;
    logic       in_ready, r, busy, terr, ack;
    logic [3:0] in_data = 0, d, rise_d = 0, last_word = 0;
    logic [1:0] ms;
    logic       r_prev = 0, seen_low = 1, ms1_prev = 0;
    bit         ack_auto = 0;
    int         ack_dly = 0, errors = 0, checks = 0, cyc = 0, last_width = -1, prev_rise = 0, last_rise = 0;
    logic [3:0] exp_q[$];
    vec_t       vecs[5];

    sensedrive_chan_tx #(.DATA_W(4), .TIMEOUT_CYC(8)) dut (
        .clk_sampler  (clk),
        .rst_sampler_n(rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .chan__out_0r (r),
        .chan__out_0d (d),
        .chan__out_0a (ack),
        .busy         (busy),
        .timeout_err  (terr),
        .err_clr      (err_clr)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign ack = ack_auto ? ack_resp : ack_man;

    // reference view of the acknowledge as the FSM should see it
    always @(posedge clk or negedge rst_n) ms <= !rst_n ? 2'b00 : {ms[0], ack};

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push_word(input logic [3:0] w);
        in_valid = 1;
        in_data  = w;
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        chk("push_ready", int'(in_ready), 1);
        if (in_ready) exp_q.push_back(w);
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && (busy || exp_q.size() != 0); i++) @(negedge clk);
        chk(name, int'(busy) + exp_q.size(), 0);
    endtask

    // responder: follows the request after ack_dly extra cycles
    initial forever begin
        int rcnt;
        @(negedge clk);
        if (!rst_n) begin
            ack_resp = 0;
            rcnt = 0;
        end else if (r != ack_resp) begin
            if (rcnt >= ack_dly) begin
                ack_resp = r;
                rcnt = 0;
            end else rcnt++;
        end else rcnt = 0;
    end

    // protocol monitor and scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            r_prev = 0;
            seen_low = 1;
            ms1_prev = 0;
        end else begin
            if (!r_prev && r) begin
                chk("rise_after_ack_low", int'(seen_low), 1);
                seen_low  = 0;
                prev_rise = last_rise;
                last_rise = cyc;
                rise_d    = d;
                chk("req_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("sb_word", int'(d), int'(exp_q.pop_front()));
            end
            if (r_prev && !r) begin
                chk("fall_after_ack_high", int'(ms1_prev), 1);
                chk("d_stable", int'(d), int'(rise_d));
                last_width = cyc - last_rise;
                last_word  = rise_d;
            end
            if (!r_prev && !r && !ms1_prev) seen_low = 1;
            r_prev   = r;
            ms1_prev = ms[1];
        end
    end

    initial begin
        vecs[0] = '{4'hA, 3, 6};
        vecs[1] = '{4'h5, 0, 3};
        vecs[2] = '{4'hF, 1, 4};
        vecs[3] = '{4'h0, 2, 5};
        vecs[4] = '{4'hC, 5, 8};

        #5;
        chk("rst_req", int'(r), 0);
        chk("rst_data", int'(d), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(terr), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_ready", int'(in_ready), 1);
        chk("post_rst_busy", int'(busy), 0);

        // single word against edge-exact timing, acknowledge driven by hand
        in_valid = 1;
        in_data  = 4'hA;
        exp_q.push_back(4'hA);
        @(negedge clk);
        in_valid = 0;
        chk("sw_req_k", int'(r), 0);
        chk("sw_busy_k", int'(busy), 1);
        @(negedge clk);
        chk("sw_data_setup", int'(d), 10);
        chk("sw_req_setup", int'(r), 0);
        @(negedge clk);
        chk("sw_req_rise", int'(r), 1);
        repeat (2) @(negedge clk);
        ack_man = 1;
        @(negedge clk);
        chk("sw_req_a0", int'(r), 1);
        @(negedge clk);
        chk("sw_req_a1", int'(r), 1);
        @(negedge clk);
        chk("sw_req_fall", int'(r), 0);
        chk("sw_data_reql", int'(d), 10);
        repeat (2) @(negedge clk);
        ack_man = 0;
        @(negedge clk);
        chk("sw_busy_b0", int'(busy), 1);
        @(negedge clk);
        chk("sw_busy_b1", int'(busy), 1);
        @(negedge clk);
        chk("sw_busy_idle", int'(busy), 0);
        chk("sw_data_hold", int'(d), 10);

        ack_auto = 1;
        for (int v = 0; v < 5; v++) begin
            ack_dly = vecs[v].dly;
            push_word(vecs[v].data);
            wait_idle("vec_idle");
            chk("vec_word", int'(last_word), int'(vecs[v].data));
            chk("vec_width", last_width, vecs[v].width);
        end
        chk("no_spurious_wd", int'(terr), 0);

        // burst with an immediate responder
        ack_dly  = 0;
        in_valid = 1;
        in_data  = 4'h1;
        exp_q.push_back(4'h1);
        @(negedge clk);
        chk("burst_ready_1", int'(in_ready), 1);
        in_data = 4'h2;
        exp_q.push_back(4'h2);
        @(negedge clk);
        chk("pushpop_cnt1", int'(in_ready), 1);
        in_data = 4'h3;
        exp_q.push_back(4'h3);
        @(negedge clk);
        in_valid = 0;
        chk("burst_full", int'(in_ready), 0);
        wait_idle("burst_idle");
        chk("b2b_interval", last_rise - prev_rise, 7);
        chk("burst_last", int'(last_word), 3);

        // watchdog with a silent, then late, responder
        ack_auto = 0;
        ack_man  = 0;
        push_word(4'h9);
        repeat (2) @(negedge clk);
        chk("wd_req_up", int'(r), 1);
        repeat (7) @(negedge clk);
        chk("wd_not_yet", int'(terr), 0);
        @(negedge clk);
        chk("wd_set", int'(terr), 1);
        chk("wd_req_held", int'(r), 1);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        chk("wd_clr", int'(terr), 0);
        @(negedge clk);
        chk("wd_sat_quiet", int'(terr), 0);
        ack_man = 1;
        repeat (3) @(negedge clk);
        chk("wd_late_fall", int'(r), 0);
        repeat (7) @(negedge clk);
        chk("wd_reql_not_yet", int'(terr), 0);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        chk("wd_set_beats_clr", int'(terr), 1);
        ack_man = 0;
        wait_idle("wd_idle");
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;

        // reset in REQH with one word still buffered
        push_word(4'h6);
        push_word(4'h7);
        @(negedge clk);
        chk("mid_reqh", int'(r), 1);
        chk("mid_busy", int'(busy), 1);
        #2 rst_n = 0;
        exp_q.delete();
        #1;
        chk("mid_rst_req", int'(r), 0);
        chk("mid_rst_data", int'(d), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        @(negedge clk);
        #2 rst_n = 1;
        repeat (10) @(negedge clk);
        chk("no_req_after_rst", int'(r), 0);
        chk("idle_after_rst", int'(busy), 0);
        ack_auto = 1;
        push_word(4'hE);
        wait_idle("post_rst_word");
        chk("post_rst_last", int'(last_word), 14);

        // randomized acknowledge glitches, edges kept clear of the sampling clock edge
        ack_auto = 0;
        ack_man  = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready && $urandom_range(0, 5) == 0) begin
                in_valid = 1;
                in_data  = 4'($urandom);
                exp_q.push_back(in_data);
            end else in_valid = 0;
            #($urandom_range(1, 4));
            ack_man = 1'($urandom_range(0, 1));
            #($urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) ack_man = ~ack_man;
        end
        @(negedge clk);
        in_valid = 0;
        ack_dly  = 0;
        ack_auto = 1;
        wait_idle("glitch_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
